// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Function : 8N1 UART receiver, mid-bit sampling via a clock-count bit timer.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       data_line,
    output logic       data_flag,
    output logic [7:0] data_byte
);

    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_half_m1 = c_cnt_w'(CLKS_PER_BIT/2 - 1);
    localparam logic [c_cnt_w-1:0] c_full_m1 = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_one     = c_cnt_w'(1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_stop  = 3'd3;
    localparam logic [2:0] c_st_wait  = 3'd4;

    logic [1:0]         r_sync;
    logic [2:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_data_byte;
    logic               r_data_flag;

    logic               w_rx_s;
    logic [2:0]         w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [2:0]         w_idx_nxt;
    logic [7:0]         w_shift_nxt;
    logic [7:0]         w_byte_nxt;
    logic               w_flag_nxt;

    assign w_rx_s    = r_sync[1];
    assign data_flag = r_data_flag;
    assign data_byte = r_data_byte;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync      <= 2'b11;
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_data_byte <= 8'h00;
            r_data_flag <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], data_line};
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_data_byte <= w_byte_nxt;
            r_data_flag <= w_flag_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_byte_nxt  = r_data_byte;
        w_flag_nxt  = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_cnt_nxt = '0;
                w_idx_nxt = 3'd0;
                if (!w_rx_s) w_state_nxt = c_st_start;
            end
            c_st_start: begin
                // A start bit that is high again at its midpoint was a glitch.
                if (r_cnt == c_half_m1) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_rx_s ? c_st_idle : c_st_data;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end
            c_st_data: begin
                if (r_cnt == c_full_m1) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_idx] = w_rx_s;
                    w_idx_nxt          = r_idx + 3'd1;
                    if (r_idx == 3'd7) w_state_nxt = c_st_stop;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end
            c_st_stop: begin
                if (r_cnt == c_full_m1) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_byte_nxt  = r_shift;
                        w_flag_nxt  = 1'b1;
                        w_state_nxt = c_st_idle;
                    end else begin
                        w_state_nxt = c_st_wait;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end
            c_st_wait: begin
                // Hold off until the line returns high so a break is not re-framed.
                if (w_rx_s) w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_rx
// Function : Randomized self-checking bench for uart_rx with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int C = 8;

    typedef struct {
        logic [7:0] b;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       data_line = 1'b1;
    logic       data_flag;
    logic [7:0] data_byte;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    bit   rst_seen = 1'b0;
    logic [7:0] last_good = 8'h00;
    exp_t exp_q[$];

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_line (data_line),
        .data_flag (data_flag),
        .data_byte (data_byte)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= !rst_n;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // A good frame's flag lands 2 synchroniser cycles + 1 detect edge +
    // half a bit + 9 bits after the line falls.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit push);
        exp_t e;
        data_line = 1'b0;
        if (push && stop_bit) begin
            e.b   = b;
            e.cyc = cyc + 3 + C/2 + 9*C;
            exp_q.push_back(e);
        end
        tick(C);
        for (int i = 0; i < 8; i++) begin
            data_line = b[i];
            tick(C);
        end
        data_line = stop_bit;
        tick(C);
        data_line = 1'b1;
    endtask

    task automatic glitch(input int len);
        data_line = 1'b0;
        tick(len);
        data_line = 1'b1;
        tick(2*C);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_seen) begin
                last_good = 8'h00;
                exp_q.delete();
            end
            if (data_flag === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_flag", data_flag, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_eq("flag_cycle", cyc, e.cyc);
                    check_eq("rx_byte", data_byte, e.b);
                    last_good = e.b;
                end
            end else begin
                check_eq("flag_low", data_flag, 1'b0);
                check_eq("byte_hold", data_byte, last_good);
                if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                    check_eq("missing_flag", data_flag, 1'b1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        bit         bad;

        // Reset values with an idle line
        rst_n = 1'b0;
        data_line = 1'b1;
        tick(3);
        rst_n = 1'b1;
        check_eq("rst_flag", data_flag, 1'b0);
        check_eq("rst_byte", data_byte, 8'h00);
        mon_en = 1'b1;
        tick(200);

        // Repeating 88-cycle 0x55 pattern
        for (int i = 0; i < 3; i++) begin
            send_frame(8'h55, 1'b1, 1'b1);
            tick(C);
        end

        // Back-to-back frames, no idle gap
        send_frame(8'hA5, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        tick(2*C);

        // Start glitch followed by a good frame
        glitch(2);
        check_eq("glitch_byte", data_byte, 8'h3C);
        send_frame(8'h96, 1'b1, 1'b1);
        tick(2*C);

        // Framing error with a held-low line
        send_frame(8'h81, 1'b0, 1'b1);
        data_line = 1'b0;
        tick(40);
        data_line = 1'b1;
        tick(2*C);
        check_eq("ferr_byte", data_byte, 8'h96);
        send_frame(8'h42, 1'b1, 1'b1);
        tick(2*C);

        // Reset pulse during data bit 4 of an all-ones frame
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                tick(5*C + 4);
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
                check_eq("midrst_flag", data_flag, 1'b0);
                check_eq("midrst_byte", data_byte, 8'h00);
            end
        join
        tick(2*C);
        send_frame(8'h12, 1'b1, 1'b1);
        tick(2*C);

        // Randomized frames, gaps, glitches and framing errors
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 5) == 0) glitch($urandom_range(1, C/2 - 1));
            b   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 5) == 0);
            send_frame(b, !bad, 1'b1);
            if (bad) begin
                data_line = 1'b0;
                tick($urandom_range(0, 30));
                data_line = 1'b1;
                tick(2*C);
            end else begin
                tick($urandom_range(0, 3*C));
            end
        end

        tick(100);
        check_eq("pending", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
